// File: rtl/frame_sync_ctrl.sv
// Serial frame synchroniser: hunts for a sync word, verifies, then tracks lock.
// Define FRAME_SYNC_ERR_CNT_EN to add the saturating missed-sync counter err_cnt.
module frame_sync_ctrl #(
  parameter logic [3:0] SYNC_WORD = 4'b1011,
  parameter int         FRAME_LEN = 16,
  parameter int         VERIFY_N  = 2,
  parameter int         LOSS_N    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       in_valid,
  output logic       locked,
  output logic [1:0] state,
  output logic       sync_hit,
  output logic       frame_start,
  output logic       data_out,
  output logic       data_valid
`ifdef FRAME_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);
  localparam logic [2:0] VN   = 3'(VERIFY_N);
  localparam logic [2:0] LN   = 3'(LOSS_N);

  state_e     state_q, state_d;
  // Older three bits of the 4-bit window; the live input is the fourth.
  logic [2:0] sr_q, sr_d;
  logic [7:0] pos_q, pos_d;
  logic [2:0] hit_q, hit_d;
  logic [2:0] miss_q, miss_d;
  logic       locked_q, locked_d;
  logic       sync_hit_q, sync_hit_d;
  logic       frame_start_q, frame_start_d;
  logic       data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
`ifdef FRAME_SYNC_ERR_CNT_EN
  logic [7:0] err_q, err_d;
`endif

  logic [3:0] window;
  logic [7:0] pos_nx;
  logic       match;
  logic       sync_pos;

  always_comb begin
    window   = {sr_q, in};
    pos_nx   = (pos_q == LAST) ? 8'd0 : pos_q + 8'd1;
    match    = (window == SYNC_WORD);
    sync_pos = (pos_nx == 8'd3);

    state_d       = state_q;
    sr_d          = sr_q;
    pos_d         = pos_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    sync_hit_d    = 1'b0;
    frame_start_d = 1'b0;
    data_out_d    = 1'b0;
    data_valid_d  = 1'b0;
`ifdef FRAME_SYNC_ERR_CNT_EN
    err_d         = err_q;
`endif

    if (in_valid) begin
      sr_d  = window[2:0];
      pos_d = pos_nx;
      if (state_q == LOCK && pos_nx >= 8'd4) begin
        data_valid_d = 1'b1;
        data_out_d   = in;
      end
      unique case (state_q)
        HUNT: begin
          if (match) begin
            state_d    = VERIFY;
            pos_d      = 8'd3;
            hit_d      = 3'd0;
            sync_hit_d = 1'b1;
          end
        end
        VERIFY: begin
          if (sync_pos) begin
            if (match) begin
              hit_d      = hit_q + 3'd1;
              sync_hit_d = 1'b1;
              if (hit_d == VN) begin
                state_d       = LOCK;
                frame_start_d = 1'b1;
                miss_d        = 3'd0;
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCK: begin
          if (sync_pos) begin
            if (match) begin
              sync_hit_d    = 1'b1;
              frame_start_d = 1'b1;
              miss_d        = 3'd0;
            end else begin
              miss_d = miss_q + 3'd1;
`ifdef FRAME_SYNC_ERR_CNT_EN
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
              if (miss_d == LN) state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sr_q          <= 3'd0;
      pos_q         <= 8'd0;
      hit_q         <= 3'd0;
      miss_q        <= 3'd0;
      locked_q      <= 1'b0;
      sync_hit_q    <= 1'b0;
      frame_start_q <= 1'b0;
      data_out_q    <= 1'b0;
      data_valid_q  <= 1'b0;
`ifdef FRAME_SYNC_ERR_CNT_EN
      err_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      pos_q         <= pos_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      locked_q      <= locked_d;
      sync_hit_q    <= sync_hit_d;
      frame_start_q <= frame_start_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
`ifdef FRAME_SYNC_ERR_CNT_EN
      err_q         <= err_d;
`endif
    end
  end

  assign locked      = locked_q;
  assign state       = state_q;
  assign sync_hit    = sync_hit_q;
  assign frame_start = frame_start_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
`ifdef FRAME_SYNC_ERR_CNT_EN
  assign err_cnt     = err_q;
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: directed scenarios plus random streams,
// every cycle compared against a bit-history reference model.
module tb_frame_sync_ctrl;

  localparam logic [3:0] SW = 4'b1011;
  localparam int FL = 16;
  localparam int VN = 2;
  localparam int LN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       locked;
  logic [1:0] state;
  logic       sync_hit;
  logic       frame_start;
  logic       data_out;
  logic       data_valid;
`ifdef FRAME_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  frame_sync_ctrl #(
    .SYNC_WORD(SW),
    .FRAME_LEN(FL),
    .VERIFY_N(VN),
    .LOSS_N(LN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .in_valid(in_valid),
    .locked(locked),
    .state(state),
    .sync_hit(sync_hit),
    .frame_start(frame_start),
    .data_out(data_out),
    .data_valid(data_valid)
`ifdef FRAME_SYNC_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail = 0;
  bit gap_en = 0;

  // Reference: accepted-bit history, frame phase and plain counters.
  bit rx[$];
  int mst, mpos, mhit, mmiss, merr;
  bit e_sync, e_fs, e_do, e_dv;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit b);
    int w, pn, n;
    e_sync = 0; e_fs = 0; e_dv = 0; e_do = 0;
    if (r) begin
      mst = 0; mpos = 0; mhit = 0; mmiss = 0; merr = 0;
      rx = {};
      for (int i = 0; i < 3; i++) rx.push_back(1'b0);
      return;
    end
    if (!v) return;
    n = rx.size();
    w = int'(rx[n-3]) * 8 + int'(rx[n-2]) * 4 + int'(rx[n-1]) * 2 + int'(b);
    rx.push_back(b);
    if (rx.size() > 8) void'(rx.pop_front());
    pn = (mpos + 1) % FL;
    if (mst == 2 && pn >= 4) begin e_dv = 1; e_do = b; end
    mpos = pn;
    if (mst == 0) begin
      if (w == int'(SW)) begin
        mst = 1; mpos = 3; mhit = 0; e_sync = 1;
      end
    end else if (pn == 3) begin
      if (w == int'(SW)) begin
        e_sync = 1;
        if (mst == 1) begin
          mhit++;
          if (mhit == VN) begin mst = 2; e_fs = 1; mmiss = 0; end
        end else begin
          e_fs = 1; mmiss = 0;
        end
      end else if (mst == 1) begin
        mst = 0;
      end else begin
        mmiss++;
        if (merr < 255) merr++;
        if (mmiss == LN) mst = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit b);
    @(negedge clk);
    rst = r; in_valid = v; in = b;
    @(posedge clk);
    #1;
    model(r, v, b);
    chk("state", 8'(state), 8'(mst));
    chk("locked", 8'(locked), 8'(mst == 2));
    chk("sync_hit", 8'(sync_hit), 8'(e_sync));
    chk("frame_start", 8'(frame_start), 8'(e_fs));
    chk("data_valid", 8'(data_valid), 8'(e_dv));
    chk("data_out", 8'(data_out), 8'(e_do));
`ifdef FRAME_SYNC_ERR_CNT_EN
    chk("err_cnt", err_cnt, 8'(merr));
`endif
  endtask

  task automatic send_bit(input bit b);
    if (gap_en)
      while ($urandom_range(0, 3) == 0) step(0, 0, 1'($urandom));
    step(0, 1, b);
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic payload(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic acquire();
    send_word(4'b0000);
    send_word(SW);
    payload(12); send_word(SW);
    payload(12); send_word(SW);
  endtask

  task automatic corrupt_frame();
    payload(12);
    send_word(4'b0000);
  endtask

  initial begin
    int dv_cnt;
    logic [3:0] wd;
    step(1, 0, 0);
    step(1, 1, 1);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_locked", 8'(locked), 8'd0);

    // Sync word after a leading zero
    send_bit(0); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("hunt_state", 8'(state), 8'd1);
    chk("hunt_hit", 8'(sync_hit), 8'd1);
    chk("hunt_locked", 8'(locked), 8'd0);

    payload(12); send_word(SW);
    chk("verify_state", 8'(state), 8'd1);
    payload(12); send_word(SW);
    chk("lock_locked", 8'(locked), 8'd1);
    chk("lock_fs", 8'(frame_start), 8'd1);

    // Alternating payload
    dv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      send_bit(1'(i % 2 == 0));
      if (data_valid === 1'b1) dv_cnt++;
      chk("alt_data", 8'(data_out), 8'(i % 2 == 0));
    end
    chk("alt_count", 8'(dv_cnt), 8'd12);
    send_word(SW);
    chk("alt_sync_dv", 8'(data_valid), 8'd0);
    chk("alt_sync_fs", 8'(frame_start), 8'd1);

    // Two misses then recover, then three misses
    corrupt_frame(); corrupt_frame();
    chk("miss2_locked", 8'(locked), 8'd1);
    payload(12); send_word(SW);
    chk("recover_fs", 8'(frame_start), 8'd1);
    corrupt_frame(); corrupt_frame();
    chk("miss2b_locked", 8'(locked), 8'd1);
    corrupt_frame();
    chk("loss_state", 8'(state), 8'd0);
    chk("loss_dv", 8'(data_valid), 8'd0);

    // Gap in the payload
    acquire();
    payload(6);
    for (int i = 0; i < 5; i++) step(0, 0, 1'($urandom));
    chk("gap_locked", 8'(locked), 8'd1);
    payload(6); send_word(SW);
    chk("gap_fs", 8'(frame_start), 8'd1);
    chk("gap_locked2", 8'(locked), 8'd1);

    // Reset while locked
    payload(5);
    step(1, 1, 1);
    chk("rst_lock_state", 8'(state), 8'd0);
    chk("rst_lock_outs",
        8'({locked, sync_hit, frame_start, data_out, data_valid}), 8'd0);
`ifdef FRAME_SYNC_ERR_CNT_EN
    chk("rst_lock_err", err_cnt, 8'd0);
`endif

    // Random streams with gaps, corruption and resets
    gap_en = 1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0: begin step(1, 1'($urandom), 1'($urandom)); acquire(); end
        1, 2: acquire();
        default: begin
          payload(12);
          wd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : SW;
          send_word(wd);
        end
      endcase
    end

    // Many loss cycles to push the miss counter to its limit
    gap_en = 0;
    step(1, 0, 0);
    for (int k = 0; k < 105; k++) begin
      acquire();
      corrupt_frame(); corrupt_frame(); corrupt_frame();
    end
    chk("sat_state", 8'(state), 8'd0);
`ifdef FRAME_SYNC_ERR_CNT_EN
    chk("sat_err", err_cnt, 8'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
